// File: rtl/hue_pkg.sv
// Shared types and constants for the hue sequencing controller.
package hue_pkg;

  typedef enum logic [2:0] {IDLE, PREP, DIV, OFFS, DONE} hue_state_t;

  localparam int HUE_OFF_G = 120;
  localparam int HUE_OFF_B = 240;
  localparam int HUE_WRAP  = 360;
  localparam int HUE_SCALE = 60;

  localparam logic [1:0] IDX_R = 2'd0;
  localparam logic [1:0] IDX_G = 2'd1;
  localparam logic [1:0] IDX_B = 2'd2;

  function automatic int hue_offset(input logic [1:0] idx);
    case (idx)
      IDX_G:   return HUE_OFF_G;
      IDX_B:   return HUE_OFF_B;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/hue_seq_ctrl_if.sv
// Pixel-in / hue-out handshake bundle; slave is the controller side.
interface hue_seq_ctrl_if #(
  parameter int PIX_W = 8,
  parameter int HUE_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] r;
  logic [PIX_W-1:0] g;
  logic [PIX_W-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [HUE_W-1:0] hue;
  logic [1:0]       max_index;
  logic             gray;

  modport master (
    output in_valid, r, g, b, out_ready,
    input  in_ready, out_valid, hue, max_index, gray
  );

  modport slave (
    input  in_valid, r, g, b, out_ready,
    output in_ready, out_valid, hue, max_index, gray
  );
endinterface

// File: rtl/hue_serial_div.sv
// Unsigned restoring divider, one quotient bit per enabled cycle.
module hue_serial_div #(
  parameter int PIX_W     = 8,
  parameter int DIV_STEPS = PIX_W + 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 start,
  input  logic [14:0]          dividend,
  input  logic [PIX_W-1:0]     divisor,
  output logic                 done,
  output logic [DIV_STEPS-1:0] quotient
);
  localparam int CW = $clog2(DIV_STEPS + 1);

  logic [PIX_W-1:0]     rem;
  logic [PIX_W-1:0]     dsr;
  logic [DIV_STEPS-1:0] shreg;
  logic [CW-1:0]        cnt;
  logic [PIX_W:0]       trial;
  logic [PIX_W:0]       diff;

  assign trial    = {rem, shreg[DIV_STEPS-1]};
  assign diff     = trial - {1'b0, dsr};
  // High during the cycle whose closing edge performs the last step.
  assign done     = ce && (cnt == CW'(1));
  assign quotient = shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      dsr   <= '0;
      shreg <= '0;
      cnt   <= '0;
    end else if (ce) begin
      if (start) begin
        rem   <= PIX_W'(dividend[14:DIV_STEPS]);
        dsr   <= divisor;
        shreg <= dividend[DIV_STEPS-1:0];
        cnt   <= CW'(DIV_STEPS);
      end else if (cnt != '0) begin
        if (!diff[PIX_W]) begin
          rem   <= diff[PIX_W-1:0];
          shreg <= {shreg[DIV_STEPS-2:0], 1'b1};
        end else begin
          rem   <= trial[PIX_W-1:0];
          shreg <= {shreg[DIV_STEPS-2:0], 1'b0};
        end
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/hue_seq_ctrl.sv
// Hue sequencer: max-channel select, serial divide, sector offset and wrap.
// state | meaning
// IDLE  | waiting for a pixel, in_ready follows ce
// PREP  | max/min select, numerator and delta, divider launch
// DIV   | serial divider running
// OFFS  | sign fix, sector offset, wrap, register result
// DONE  | result held until out_ready
module hue_seq_ctrl
  import hue_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int HUE_W     = 12,
  parameter int DIV_STEPS = PIX_W + 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  hue_seq_ctrl_if.slave  bus
);
  localparam int AW = DIV_STEPS + 2;

  hue_state_t           state;
  logic [PIX_W-1:0]     r_q, g_q, b_q;
  logic [1:0]           idx_q;
  logic                 neg_q;
  logic                 gray_q;

  logic [1:0]           idx_c;
  logic [PIX_W-1:0]     max_c, min_c, delta_c;
  logic signed [14:0]   diff_c, num_c;
  logic [14:0]          num_abs;
  logic                 div_start, div_done;
  logic [DIV_STEPS-1:0] quotient;
  logic signed [AW-1:0] q_s, hue_c;

  assign bus.in_ready = (state == IDLE) && ce;

  always_comb begin
    idx_c  = IDX_R;
    max_c  = r_q;
    diff_c = $signed(15'(g_q)) - $signed(15'(b_q));
    if (!(r_q >= g_q && r_q >= b_q)) begin
      if (g_q >= b_q) begin
        idx_c  = IDX_G;
        max_c  = g_q;
        diff_c = $signed(15'(b_q)) - $signed(15'(r_q));
      end else begin
        idx_c  = IDX_B;
        max_c  = b_q;
        diff_c = $signed(15'(r_q)) - $signed(15'(g_q));
      end
    end
    min_c = r_q;
    if (g_q < min_c) min_c = g_q;
    if (b_q < min_c) min_c = b_q;
    delta_c = max_c - min_c;
    num_c   = diff_c * $signed(15'(HUE_SCALE));
    num_abs = num_c[14] ? 15'(-num_c) : num_c;
  end

  assign div_start = (state == PREP) && (delta_c != '0);

  hue_serial_div #(.PIX_W(PIX_W), .DIV_STEPS(DIV_STEPS)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .start    (div_start),
    .dividend (num_abs),
    .divisor  (delta_c),
    .done     (div_done),
    .quotient (quotient)
  );

  // Divider output is stale for achromatic pixels, so force the quotient to zero.
  always_comb begin
    q_s   = gray_q ? '0 : $signed(AW'(quotient));
    hue_c = (neg_q ? -q_s : q_s) + $signed(AW'(hue_offset(idx_q)));
    if (hue_c < 0) hue_c = hue_c + $signed(AW'(HUE_WRAP));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      idx_q         <= IDX_R;
      neg_q         <= 1'b0;
      gray_q        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.hue       <= '0;
      bus.max_index <= IDX_R;
      bus.gray      <= 1'b0;
    end else if (ce) begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          r_q   <= bus.r;
          g_q   <= bus.g;
          b_q   <= bus.b;
          state <= PREP;
        end
        PREP: begin
          idx_q  <= idx_c;
          neg_q  <= num_c[14];
          gray_q <= (delta_c == '0);
          state  <= (delta_c == '0) ? OFFS : DIV;
        end
        DIV: if (div_done) state <= OFFS;
        OFFS: begin
          bus.hue       <= HUE_W'(hue_c);
          bus.max_index <= idx_q;
          bus.gray      <= gray_q;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hue_seq_ctrl.sv
// Directed bench for hue_seq_ctrl: vector table plus multi-cycle corner sequences.
module tb_hue_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   lat;

  hue_seq_ctrl_if #(.PIX_W(8), .HUE_W(12)) bus ();

  hue_seq_ctrl #(.PIX_W(8), .HUE_W(12), .DIV_STEPS(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r, g, b;
    int hue, idx, gray, lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus.r = r; bus.g = g; bus.b = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int lat0, output int l);
    l = lat0;
    do begin
      tick();
      l++;
    end while (!bus.out_valid && l < 200);
  endtask

  task automatic consume(input string name);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({name, "_ov_clear"}, bus.out_valid, 0);
    check({name, "_ready_back"}, bus.in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'd255, 8'd0,   8'd0,   0,   0, 0, 16};
    vecs[1]  = '{8'd0,   8'd255, 8'd0,   120, 1, 0, 16};
    vecs[2]  = '{8'd0,   8'd0,   8'd255, 240, 2, 0, 16};
    vecs[3]  = '{8'd255, 8'd0,   8'd128, 330, 0, 0, 16};
    vecs[4]  = '{8'd50,  8'd200, 8'd100, 140, 1, 0, 16};
    vecs[5]  = '{8'd100, 8'd100, 8'd100, 0,   0, 1, 2};
    vecs[6]  = '{8'd200, 8'd200, 8'd10,  60,  0, 0, 16};
    vecs[7]  = '{8'd10,  8'd20,  8'd200, 237, 2, 0, 16};
    vecs[8]  = '{8'd200, 8'd10,  8'd20,  357, 0, 0, 16};
    vecs[9]  = '{8'd0,   8'd0,   8'd0,   0,   0, 1, 2};
    vecs[10] = '{8'd5,   8'd5,   8'd9,   240, 2, 0, 16};

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.r = '0; bus.g = '0; bus.b = '0;

    repeat (3) tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_hue", bus.hue, 0);
    check("rst_max_index", bus.max_index, 0);
    check("rst_gray", bus.gray, 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", bus.in_ready, 1);
    ce = 1'b0;
    #1;
    check("ce_low_in_ready", bus.in_ready, 0);
    ce = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      accept(vecs[i].r, vecs[i].g, vecs[i].b);
      wait_out(0, lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_hue", i), bus.hue, vecs[i].hue);
      check($sformatf("vec%0d_max_index", i), bus.max_index, vecs[i].idx);
      check($sformatf("vec%0d_gray", i), bus.gray, vecs[i].gray);
      consume($sformatf("vec%0d", i));
    end

    // Backpressure in DONE with a new pixel already offered.
    accept(8'd0, 8'd255, 8'd0);
    wait_out(0, lat);
    check("bp_latency", lat, 16);
    bus.r = 8'd0; bus.g = 8'd0; bus.b = 8'd255;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp%0d_out_valid", i), bus.out_valid, 1);
      check($sformatf("bp%0d_hue", i), bus.hue, 120);
      check($sformatf("bp%0d_in_ready", i), bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_release_ov", bus.out_valid, 0);
    check("bp_release_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_next_accepted", bus.in_ready, 0);
    wait_out(0, lat);
    check("bp_next_latency", lat, 16);
    check("bp_next_hue", bus.hue, 240);

    // ce low in DONE: out_ready ignored, result held.
    ce = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("ce_done%0d_out_valid", i), bus.out_valid, 1);
      check($sformatf("ce_done%0d_hue", i), bus.hue, 240);
    end
    ce = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("ce_done_consumed", bus.out_valid, 0);

    // ce low for 3 cycles mid-DIV stretches latency by 3.
    accept(8'd50, 8'd200, 8'd100);
    repeat (5) tick();
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ce_div%0d_out_valid", i), bus.out_valid, 0);
    end
    ce = 1'b1;
    wait_out(8, lat);
    check("ce_div_latency", lat, 19);
    check("ce_div_hue", bus.hue, 140);
    check("ce_div_max_index", bus.max_index, 1);
    consume("ce_div");

    // Reset pulse mid-DIV discards the pending result.
    accept(8'd255, 8'd0, 8'd128);
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_hue", bus.hue, 0);
    tick();
    rst_n = 1'b1;
    check("rst_mid_in_ready", bus.in_ready, 1);
    accept(8'd0, 8'd0, 8'd255);
    wait_out(0, lat);
    check("rst_after_latency", lat, 16);
    check("rst_after_hue", bus.hue, 240);
    check("rst_after_max_index", bus.max_index, 2);
    consume("rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
